// File: rtl/pipe_pkg.sv
// Shared types and helpers for the EX/MEM pipeline register: the control bundle
// carried between stages and the valid-gating function applied on entry.
package pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
  } exmem_ctrl_t;

  // An invalid entry must never write memory or the register file.
  function automatic exmem_ctrl_t gate_ctrl(input exmem_ctrl_t ctrl, input logic valid);
    gate_ctrl = exmem_ctrl_t'(ctrl & {4{valid}});
  endfunction

endpackage

// File: rtl/exmem_slot.sv
// One EX/MEM register slot: flush clears valid/controls (data holds),
// stall holds everything, otherwise the slot loads its upstream entry.
module exmem_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               load_valid,
  input  exmem_ctrl_t        load_ctrl,
  input  logic [DATA_W-1:0]  load_alu_result,
  input  logic [DATA_W-1:0]  load_store_data,
  input  logic [RADDR_W-1:0] load_rd,
  output logic               valid,
  output exmem_ctrl_t        ctrl,
  output logic [DATA_W-1:0]  alu_result,
  output logic [DATA_W-1:0]  store_data,
  output logic [RADDR_W-1:0] rd
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid      <= 1'b0;
      ctrl       <= '0;
      alu_result <= '0;
      store_data <= '0;
      rd         <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (!stall) begin
      valid      <= load_valid;
      ctrl       <= load_ctrl;
      alu_result <= load_alu_result;
      store_data <= load_store_data;
      rd         <= load_rd;
    end
  end

endmodule

// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with stall/flush, a STAGES-deep slot chain and
// forwarding-hit flags. Define EXMEM_PERF_CNT_EN to add stall/bubble counters.
module exmem_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int STAGES  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic               reg_write_i,
  input  logic               mem_write_i,
  input  logic               mem_read_i,
  input  logic               mem_to_reg_i,
  input  logic [DATA_W-1:0]  alu_result_i,
  input  logic [DATA_W-1:0]  store_data_i,
  input  logic [RADDR_W-1:0] rd_i,
  input  logic [RADDR_W-1:0] fwd_rs_i,
  input  logic [RADDR_W-1:0] fwd_rt_i,
  output logic               valid_o,
  output logic               reg_write_o,
  output logic               mem_write_o,
  output logic               mem_read_o,
  output logic               mem_to_reg_o,
  output logic [DATA_W-1:0]  alu_result_o,
  output logic [DATA_W-1:0]  store_data_o,
  output logic [RADDR_W-1:0] rd_o,
  output logic               fwd_rs_hit_o,
  output logic               fwd_rt_hit_o
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        bubble_cnt_o
`endif
);

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("exmem_pipe_reg: STAGES must be in 1..4");
    end
  endgenerate

  // Element 0 is the gated EX input; element k+1 is the output of slot k.
  logic               valid_chain [STAGES+1];
  exmem_ctrl_t        ctrl_chain  [STAGES+1];
  logic [DATA_W-1:0]  alu_chain   [STAGES+1];
  logic [DATA_W-1:0]  store_chain [STAGES+1];
  logic [RADDR_W-1:0] rd_chain    [STAGES+1];
  exmem_ctrl_t        in_ctrl;

  assign in_ctrl        = {reg_write_i, mem_write_i, mem_read_i, mem_to_reg_i};
  assign valid_chain[0] = valid_i;
  assign ctrl_chain[0]  = gate_ctrl(in_ctrl, valid_i);
  assign alu_chain[0]   = alu_result_i;
  assign store_chain[0] = store_data_i;
  assign rd_chain[0]    = rd_i;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slot
      exmem_slot #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
      ) u_slot (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall_i),
        .flush           (flush_i),
        .load_valid      (valid_chain[gi]),
        .load_ctrl       (ctrl_chain[gi]),
        .load_alu_result (alu_chain[gi]),
        .load_store_data (store_chain[gi]),
        .load_rd         (rd_chain[gi]),
        .valid           (valid_chain[gi+1]),
        .ctrl            (ctrl_chain[gi+1]),
        .alu_result      (alu_chain[gi+1]),
        .store_data      (store_chain[gi+1]),
        .rd              (rd_chain[gi+1])
      );
    end
  endgenerate

  assign valid_o      = valid_chain[STAGES];
  assign reg_write_o  = ctrl_chain[STAGES].reg_write;
  assign mem_write_o  = ctrl_chain[STAGES].mem_write;
  assign mem_read_o   = ctrl_chain[STAGES].mem_read;
  assign mem_to_reg_o = ctrl_chain[STAGES].mem_to_reg;
  assign alu_result_o = alu_chain[STAGES];
  assign store_data_o = store_chain[STAGES];
  assign rd_o         = rd_chain[STAGES];

  // Register 0 is hard-wired, so it never produces a forwarding hit.
  assign fwd_rs_hit_o = valid_o & reg_write_o & (rd_o != '0) & (rd_o == fwd_rs_i);
  assign fwd_rt_hit_o = valid_o & reg_write_o & (rd_o != '0) & (rd_o == fwd_rt_i);

`ifdef EXMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (stall_i && !flush_i && stall_cnt_o != 32'hFFFF_FFFF)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      // Slot 0 ends up invalid either by flush or by loading an invalid entry.
      if ((flush_i || (!stall_i && !valid_i)) && bubble_cnt_o != 32'hFFFF_FFFF)
        bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/exmem_pipe_reg.md
Name: exmem_pipe_reg

Overview:
Parametrised EX/MEM pipeline register that replaces the fixed-width, unstallable stage register. It carries the ALU result, store data, destination register and memory/writeback controls from EX to MEM. It adds a valid bit, stall (hold) and flush (bubble insert), an optional multi-slot retiming chain, and forwarding-hit flags for the hazard unit. Complete reset of all outputs is required.

Parameters:
DATA_W, 32, width of ALU result and store data
RADDR_W, 5, register-index width
STAGES, 1, number of chained slots (1..4); total latency in cycles

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall_i  in  1  hold all slots this cycle
flush_i  in  1  convert all slots to bubbles this cycle
valid_i  in  1  EX-stage instruction valid
reg_write_i  in  1  writeback enable
mem_write_i  in  1  data-memory write
mem_read_i  in  1  data-memory read
mem_to_reg_i  in  1  writeback source select
alu_result_i  in  DATA_W  ALU result / memory address
store_data_i  in  DATA_W  store data
rd_i  in  RADDR_W  destination register
fwd_rs_i  in  RADDR_W  EX source index rs (hazard lookup)
fwd_rt_i  in  RADDR_W  EX source index rt (hazard lookup)
valid_o  out  1  last-slot valid
reg_write_o, mem_write_o, mem_read_o, mem_to_reg_o  out  1 each  last-slot controls
alu_result_o  out  DATA_W  last-slot ALU result
store_data_o  out  DATA_W  last-slot store data
rd_o  out  RADDR_W  last-slot destination
fwd_rs_hit_o  out  1  last slot will write fwd_rs_i
fwd_rt_hit_o  out  1  last slot will write fwd_rt_i

Behaviour:
- Reset (rst=0, async): every slot's valid, controls, data and rd cleared to 0; all outputs 0 until the first load after deassertion.
- Per rising edge, priority flush > stall > load.
- Load: slot0 takes inputs; slot k takes slot k-1. Each control bit is stored ANDed with valid_i, so an invalid entry never writes memory or registers. Latency from input to output is exactly STAGES cycles.
- Stall (flush_i=0): all slots hold every field; no shift.
- Flush: all slots get valid=0 and all four controls 0. Data/rd hold previous values (don't-care). Flush applies even when stall_i=1.
- Simultaneous stall+flush: flush result, no shift.
- Hit flags (combinational from last slot): hit = valid_o & reg_write_o & (rd_o != 0) & (rd_o == fwd_x_i). Register 0 never hits.
- Reset asserted mid-operation: contents lost immediately; no partial shift completes.
- STAGES outside 1..4: elaboration error.

Optional Feature:
Macro EXMEM_PERF_CNT_EN.
- With it: adds outputs stall_cnt_o[31:0] and bubble_cnt_o[31:0]. stall_cnt_o increments on each edge with stall_i=1 & flush_i=0. bubble_cnt_o increments on each edge where slot0 loads or is flushed to valid=0. Both saturate at 32'hFFFFFFFF and are cleared by rst.
- Without it: ports and logic absent.

Decomposition:
- Shared package pipe_pkg holds typedef struct exmem_ctrl_t {reg_write, mem_write, mem_read, mem_to_reg}, a function for the ctrl bitwise-AND with valid, and the constants DATA_W_DEF=32 and RADDR_W_DEF=5.
- One sub-module exmem_slot: a single register slot with load/hold/flush. It is instantiated STAGES times by a generate loop.

Test Plan:
1. Reset: rst=0 with inputs nonzero -> all outputs 0; release rst, load alu=32'h0000_1234, rd=5, reg_write=1, valid=1 -> outputs match after 1 cycle (STAGES=1).
2. Stall: load rd=7 alu=32'hDEAD_BEEF, then stall_i=1 for 3 cycles while inputs change -> outputs hold 32'hDEAD_BEEF / rd=7 for all 3 cycles.
3. Flush vs stall: valid entry in slot with mem_write=1; assert stall_i=1 and flush_i=1 -> next cycle valid_o=0, mem_write_o=0, reg_write_o=0.
4. Invalid gating: valid_i=0, mem_write_i=1, reg_write_i=1 -> mem_write_o=0, reg_write_o=0, valid_o=0.
5. Forwarding: last slot rd=9 reg_write=1 valid=1, fwd_rs_i=9, fwd_rt_i=3 -> rs_hit=1, rt_hit=0; the same test with rd=0 and fwd_rs_i=0 -> rs_hit=0.
6. STAGES=3: inputs A, B, C on consecutive cycles -> A appears at cycle 3; one stall at cycle 2 delays A to cycle 4. With EXMEM_PERF_CNT_EN, stall_cnt_o=1.
